// File: rtl/watch_pkg.sv
// Shared watch definitions: button count and the bit position of each button.
package watch_pkg;

  localparam int unsigned N_BTN     = 5;

  localparam int unsigned BTN_MODE  = 0;
  localparam int unsigned BTN_SET   = 1;
  localparam int unsigned BTN_INC   = 2;
  localparam int unsigned BTN_DEC   = 3;
  localparam int unsigned BTN_LIGHT = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle: raw inputs from the pads, conditioned level and press pulses back out.
// The slave modport is the conditioner; the master modport is whoever drives the pads.
interface button_conditioner_if #(
  parameter int unsigned Width = watch_pkg::N_BTN
);

  logic [Width-1:0] btn_raw;
  logic [Width-1:0] btn_level;
  logic [Width-1:0] btn_press;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press
  );

endinterface

// File: rtl/btn_debounce.sv
// Single-button conditioner: two-flop synchroniser, debounce counter, clean level and a
// one-cycle pulse in the cycle the level first reads 1.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned    CntW    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_d, sync1_q;
  logic            sync2_d, sync2_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            level_d, level_q;
  logic            press_d, press_q;

  // Next state: the counter only runs while the synchronised input disagrees with the level,
  // so any excursion shorter than DEBOUNCE_CYCLES restarts it from zero.
  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Front end for the raw watch buttons: one btn_debounce per button, plus optional
// auto-repeat for selected buttons when BTN_AUTOREPEAT_EN is defined.
module button_conditioner #(
  parameter int unsigned N_BTN           = watch_pkg::N_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned REPEAT_DELAY    = 1500000,
  parameter int unsigned REPEAT_PERIOD   = 250000,
  parameter int unsigned REPEAT_MASK     = 32'b01100
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  btn
);

  // Elaboration-time sanity checks on the configuration.
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be at least 2");
  end
  if ((REPEAT_MASK >> N_BTN) != 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_chk_repeat
    $error("button_conditioner: bad auto-repeat configuration");
  end

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] deb_press;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (btn.btn_raw[i]),
      .level_o (level[i]),
      .press_o (deb_press[i])
    );
  end

  assign btn.btn_level = level;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RepMax  = watch_pkg::max_u(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned RepCntW = (RepMax > 2) ? $clog2(RepMax) : 1;
  localparam logic [N_BTN-1:0]   RepMask    = N_BTN'(REPEAT_MASK);
  localparam logic [RepCntW-1:0] DelayLast  = RepCntW'(REPEAT_DELAY - 1);
  localparam logic [RepCntW-1:0] PeriodLast = RepCntW'(REPEAT_PERIOD - 1);

  logic [N_BTN-1:0][RepCntW-1:0] rep_cnt_d, rep_cnt_q;
  logic [N_BTN-1:0]              rep_first_d, rep_first_q;
  logic [N_BTN-1:0]              rep_pulse_d, rep_pulse_q;

  // Repeat timing: the counter starts at 0 in the press-pulse cycle and counts while held;
  // rep_first_q selects the initial delay versus the steady repeat period.
  always_comb begin
    rep_cnt_d   = '0;
    rep_first_d = '0;
    rep_pulse_d = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (RepMask[i] && level[i]) begin
        if (rep_cnt_q[i] == (rep_first_q[i] ? PeriodLast : DelayLast)) begin
          rep_pulse_d[i] = 1'b1;
          rep_first_d[i] = 1'b1;
        end else begin
          rep_cnt_d[i]   = rep_cnt_q[i] + RepCntW'(1);
          rep_first_d[i] = rep_first_q[i];
        end
      end
    end
  end

  // Repeat state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= '0;
      rep_pulse_q <= '0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      rep_pulse_q <= rep_pulse_d;
    end
  end

  // Gate with level so a repeat that lines up with the release cycle is dropped.
  assign btn.btn_press = deb_press | (rep_pulse_q & level);
`else
  assign btn.btn_press = deb_press;
`endif

endmodule
